// File: rtl/sass_poly_voice_if.sv
// Key/tuning inputs and audio/status outputs of the polyphonic voice engine.
// The master modport drives keys; the slave modport is the engine itself.
interface sass_poly_voice_if #(
    parameter int NUM_KEYS   = 15,
    parameter int NUM_VOICES = 4,
    parameter int ACC_W      = 16
);
    logic                      enable;
    logic [NUM_KEYS-1:0]       piano_keys;
    logic [NUM_KEYS*ACC_W-1:0] key_inc;
    logic                      pwm_o;
    logic [NUM_VOICES-1:0]     voice_active;
    logic                      voices_full;
    logic                      steal_pulse;

    modport master (
        output enable, piano_keys, key_inc,
        input  pwm_o, voice_active, voices_full, steal_pulse
    );

    modport slave (
        input  enable, piano_keys, key_inc,
        output pwm_o, voice_active, voices_full, steal_pulse
    );
endinterface

// File: rtl/sass_poly_voice.sv
// Polyphonic square-wave voice engine: key edge detection, voice allocation with
// round-robin stealing, per-voice phase accumulators and a PWM mixer.
module sass_poly_voice #(
    parameter int NUM_KEYS   = 15,
    parameter int NUM_VOICES = 4,
    parameter int ACC_W      = 16,
    parameter int PWM_W      = 8
) (
    input  logic               hwclk,
    input  logic               n_rst,
    sass_poly_voice_if.slave   bus
);
    localparam int KEY_W     = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int VOICE_W   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int SUM_W     = $clog2(NUM_VOICES + 1);
    localparam int DUTY_STEP = ((1 << PWM_W) - 1) / NUM_VOICES;

    logic [NUM_KEYS-1:0]   r_sync1;
    logic [NUM_KEYS-1:0]   r_sync2;
    logic [NUM_KEYS-1:0]   r_prev;
    logic [NUM_KEYS-1:0]   r_rise;
    logic [NUM_KEYS-1:0]   r_fall;
    logic [NUM_KEYS-1:0]   r_pend_press;
    logic [NUM_KEYS-1:0]   r_pend_rel;

    logic [NUM_VOICES-1:0] r_active;
    logic [KEY_W-1:0]      r_key [NUM_VOICES];
    logic [ACC_W-1:0]      r_acc [NUM_VOICES];
    logic [VOICE_W-1:0]    r_steal_ptr;
    logic                  r_steal;

    logic [PWM_W-1:0]      r_pwm_cnt;
    logic [PWM_W-1:0]      r_duty;
    logic                  r_pwm;

    logic                  w_svc_rel;
    logic                  w_svc_press;
    logic [KEY_W-1:0]      w_svc_key;
    logic                  w_free_any;
    logic [VOICE_W-1:0]    w_free_idx;
    logic [VOICE_W-1:0]    w_alloc_idx;
    logic                  w_steal;
    logic [NUM_KEYS-1:0]   w_pend_press_nxt;
    logic [NUM_KEYS-1:0]   w_pend_rel_nxt;
    logic [ACC_W-1:0]      w_inc [NUM_VOICES];
    logic [SUM_W-1:0]      w_sum;
    logic [PWM_W-1:0]      w_target;

    // Two-flop synchronizer followed by registered rise/fall pulses.
    always_ff @(posedge hwclk or negedge n_rst) begin
        if (!n_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
        end else begin
            r_sync1 <= bus.piano_keys;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_rise  <= r_sync2 & ~r_prev;
            r_fall  <= ~r_sync2 & r_prev;
        end
    end

    // Releases outrank presses; descending scan leaves the lowest key selected.
    always_comb begin
        w_svc_rel   = |r_pend_rel;
        w_svc_press = ~(|r_pend_rel) & (|r_pend_press);
        w_svc_key   = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (w_svc_rel) begin
                if (r_pend_rel[k]) w_svc_key = KEY_W'(k);
            end else if (r_pend_press[k]) begin
                w_svc_key = KEY_W'(k);
            end
        end
    end

    always_comb begin
        w_free_any = ~(&r_active);
        w_free_idx = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!r_active[v]) w_free_idx = VOICE_W'(v);
        end
        w_alloc_idx = w_free_any ? w_free_idx : r_steal_ptr;
        w_steal     = w_svc_press & ~w_free_any;
    end

    // Service clear happens first so a fresh edge on the same key still lands.
    always_comb begin
        w_pend_press_nxt = r_pend_press;
        w_pend_rel_nxt   = r_pend_rel;
        if (w_svc_rel)   w_pend_rel_nxt[w_svc_key]   = 1'b0;
        if (w_svc_press) w_pend_press_nxt[w_svc_key] = 1'b0;
        w_pend_press_nxt = (w_pend_press_nxt | r_rise) & ~r_fall;
        w_pend_rel_nxt   = (w_pend_rel_nxt | r_fall) & ~r_rise;
    end

    always_ff @(posedge hwclk or negedge n_rst) begin
        if (!n_rst) begin
            r_pend_press <= '0;
            r_pend_rel   <= '0;
        end else if (!bus.enable) begin
            r_pend_press <= '0;
            r_pend_rel   <= '0;
        end else begin
            r_pend_press <= w_pend_press_nxt;
            r_pend_rel   <= w_pend_rel_nxt;
        end
    end

    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            w_inc[v] = bus.key_inc[int'(r_key[v]) * ACC_W +: ACC_W];
        end
    end

    // A voice claimed this edge starts from phase 0 and skips its first add.
    always_ff @(posedge hwclk or negedge n_rst) begin
        if (!n_rst) begin
            r_active <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_key[v] <= '0;
                r_acc[v] <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (!bus.enable) begin
                    r_active[v] <= 1'b0;
                    r_key[v]    <= '0;
                    r_acc[v]    <= '0;
                end else if (w_svc_press && (w_alloc_idx == VOICE_W'(v))) begin
                    r_active[v] <= 1'b1;
                    r_key[v]    <= w_svc_key;
                    r_acc[v]    <= '0;
                end else if (w_svc_rel && r_active[v] && (r_key[v] == w_svc_key)) begin
                    r_active[v] <= 1'b0;
                    r_acc[v]    <= '0;
                end else if (r_active[v]) begin
                    r_acc[v]    <= r_acc[v] + w_inc[v];
                end
            end
        end
    end

    always_ff @(posedge hwclk or negedge n_rst) begin
        if (!n_rst) begin
            r_steal_ptr <= '0;
            r_steal     <= 1'b0;
        end else if (!bus.enable) begin
            r_steal_ptr <= '0;
            r_steal     <= 1'b0;
        end else begin
            r_steal <= w_steal;
            if (w_steal) begin
                r_steal_ptr <= (r_steal_ptr == VOICE_W'(NUM_VOICES - 1)) ? '0 : r_steal_ptr + 1'b1;
            end
        end
    end

    always_comb begin
        w_sum = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            w_sum = w_sum + SUM_W'(r_active[v] & r_acc[v][ACC_W-1]);
        end
        w_target = PWM_W'(int'(w_sum) * DUTY_STEP);
    end

    // Duty only changes at the period boundary so each period is glitch-free.
    always_ff @(posedge hwclk or negedge n_rst) begin
        if (!n_rst) begin
            r_pwm_cnt <= '0;
            r_duty    <= '0;
            r_pwm     <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            if (!bus.enable) begin
                r_duty <= '0;
            end else if (&r_pwm_cnt) begin
                r_duty <= w_target;
            end
            r_pwm <= bus.enable & (r_pwm_cnt < r_duty);
        end
    end

    assign bus.pwm_o        = r_pwm;
    assign bus.voice_active = r_active;
    assign bus.voices_full  = &r_active;
    assign bus.steal_pulse  = r_steal;

endmodule

// File: doc/sass_poly_voice.md
Name: sass_poly_voice

Overview:
- Parametrised polyphonic successor to the single-voice piano path in sass_synth: keys drive up to NUM_VOICES simultaneous square-wave voices instead of one.
- Detects key presses and releases, allocates voices (lowest free index first, round-robin stealing when all voices are busy), runs one phase accumulator per voice, and mixes the voice outputs into a single registered PWM output.
- Sits between the piano-key inputs and the audio pin.

Parameters:
- NUM_KEYS, 15, number of key inputs.
- NUM_VOICES, 4, number of simultaneous voices (≥1).
- ACC_W, 16, phase accumulator / tuning word width.
- PWM_W, 8, PWM counter width; period = 2^PWM_W clocks.

Ports:
- hwclk  in  1  system clock.
- n_rst  in  1  asynchronous active-low reset.
- enable  in  1  voice engine power; low = all voices silenced.
- piano_keys  in  NUM_KEYS  raw key levels (async, debounced upstream).
- key_inc  in  NUM_KEYS*ACC_W  per-key tuning increment, key k at [k*ACC_W +: ACC_W].
- pwm_o  out  1  mixed PWM audio.
- voice_active  out  NUM_VOICES  per-voice active flags.
- voices_full  out  1  all voices active.
- steal_pulse  out  1  one-cycle pulse when a voice is stolen.

Behaviour:
- Reset: all voices inactive with phase 0; pending vectors, steal pointer, PWM counter and duty all 0; all outputs 0.
- Input path: piano_keys pass through a 2-flop synchronizer, then a registered previous-value edge detector.
- Press edge on key k: sets pend_press[k] and clears pend_release[k].
- Release edge on key k: sets pend_release[k] and clears pend_press[k].
- Event service: at most one event per clock.
  - Any pending release beats any pending press; within a class, lowest key index wins.
  - The serviced pending bit clears on the same edge the voice state updates.
- Release of k: the voice holding k (if any) becomes inactive, phase 0. No voice holding k → no-op, bit still cleared.
- Press of k:
  - Free voice available: lowest-index free voice takes key=k, phase=0, active=1.
  - No free voice: the voice at steal_ptr takes k with phase 0; steal_ptr increments modulo NUM_VOICES; steal_pulse=1 for that cycle.
- Latency: stable key rise (sampled at edge 0) → voice_active bit high after edge 4 when no other event is pending. Fall → low after edge 4 likewise.
- Accumulator: every cycle each active voice does acc <= acc + key_inc[key], wrapping mod 2^ACC_W. A voice newly allocated this edge loads 0 and does not add.
  - Voice output = acc[ACC_W-1].
- Mixer: sum = count of active voices with MSB=1 (0..NUM_VOICES).
  - localparam DUTY_STEP = (2^PWM_W-1)/NUM_VOICES (integer division).
  - target = sum*DUTY_STEP, width PWM_W.
- PWM:
  - pwm_cnt free-runs 0..2^PWM_W-1 and wraps.
  - duty is loaded from target only on the edge where pwm_cnt wraps to 0, so there are no mid-period glitches.
  - pwm_o registered = (pwm_cnt < duty).
- voices_full = &voice_active (combinational from registers).
- enable low:
  - Voices, phases and pending vectors cleared; steal_ptr reset to 0.
  - duty forced to 0, so pwm_o goes 0 from the next edge.
  - Synchronizer and edge detector keep running; edges seen while disabled are discarded.
- Rising enable with keys held: no press events are generated for those keys until they are released and pressed again.
- Press and release of the same key both detected before service: the later edge wins per the set/clear rules above.
- Reset asserted mid-operation: immediate return to reset state; no pulse outputs.

Test Plan:
- Reset with keys held; release n_rst → all outputs 0; pressing key 3 (key_inc[3]=0x0400) gives voice_active=0001 after 4 clocks and an acc MSB period of 64 clocks.
- Press keys 0,1,2,3 in the same cycle → voices 0..3 allocated to keys 0..3 on 4 consecutive cycles; voices_full=1; no steal_pulse.
- With 4 voices full, press key 7 → voice 0 stolen, steal_pulse for 1 cycle, steal_ptr=1; press key 8 → voice 1 stolen.
- Release key 1 while key 5's press is pending in the same cycle → release serviced first (voice 1 freed), then key 5 takes voice 1.
- Two voices with MSB=1 (NUM_VOICES=4, PWM_W=8) → duty=126 from the next period start; pwm_o high for 126 of 256 clocks.
- Drop enable mid-note → voice_active=0 next edge; pwm_o=0 next edge; re-enable with keys held → no voices until a re-press.
